// File: rtl/predictor_pkg.sv
// Shared types and helpers for the branch-history-table predictor.
// Helpers work on the widest supported widths; callers zero-extend and slice.
package predictor_pkg;

  localparam int unsigned MaxCtrBits = 4;
  localparam int unsigned MaxIdxBits = 32;

  typedef logic [MaxCtrBits-1:0] ctr_wide_t;
  typedef logic [MaxIdxBits-1:0] idx_wide_t;

  // Up/down saturating counter step between 0 and max.
  function automatic ctr_wide_t sat_update(ctr_wide_t ctr, logic taken, ctr_wide_t max);
    ctr_wide_t res;
    res = ctr;
    if (taken) begin
      if (ctr != max) begin
        res = ctr + ctr_wide_t'(1);
      end
    end else begin
      if (ctr != '0) begin
        res = ctr - ctr_wide_t'(1);
      end
    end
    return res;
  endfunction

  // gshare hash; a zero ghr degenerates to bimodal indexing.
  function automatic idx_wide_t bht_hash(idx_wide_t pc_slice, idx_wide_t ghr);
    return pc_slice ^ ghr;
  endfunction

endpackage

// File: rtl/predictor_table.sv
// Flop array of saturating counters: one combinational read port, one training write port.
module predictor_table
  import predictor_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned INIT_CTR   = (1 << CTR_BITS) - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] read_index,
  output logic [CTR_BITS-1:0]   read_ctr,
  input  logic                  write_en,
  input  logic [INDEX_BITS-1:0] write_index,
  input  logic                  write_taken
);

  localparam int unsigned Entries = 1 << INDEX_BITS;

  typedef logic [CTR_BITS-1:0] ctr_t;

  localparam ctr_t      InitCtr = ctr_t'(INIT_CTR);
  localparam ctr_wide_t MaxCtr  = ctr_wide_t'((1 << CTR_BITS) - 1);

  ctr_t      ctr_q [Entries];
  ctr_wide_t upd_wide;
  ctr_t      upd_ctr;

  always_comb begin
    upd_wide = sat_update(ctr_wide_t'(ctr_q[write_index]), write_taken, MaxCtr);
    upd_ctr  = upd_wide[CTR_BITS-1:0];
  end

  generate
    if (CTR_BITS < MaxCtrBits) begin : g_unused_upd
      logic unused_upd;
      assign unused_upd = ^upd_wide[MaxCtrBits-1:CTR_BITS];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Entries; i++) begin
        ctr_q[i] <= InitCtr;
      end
    end else if (write_en) begin
      ctr_q[write_index] <= upd_ctr;
    end
  end

  // Reads see the value before any same-cycle write.
  assign read_ctr = ctr_q[read_index];

endmodule

// File: rtl/bht_predictor.sv
// gshare/bimodal branch predictor: registered lookup, training on resolved branches,
// global history register and a saturating mispredict counter.
module bht_predictor
  import predictor_pkg::*;
#(
  parameter int unsigned PC_BITS    = 32,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned GHR_BITS   = 4,
  parameter int unsigned INIT_CTR   = (1 << CTR_BITS) - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  request,
  input  logic [PC_BITS-1:0]    request_pc,
  output logic                  prediction,
  output logic                  prediction_valid,
  output logic [INDEX_BITS-1:0] prediction_index,
  input  logic                  result,
  input  logic [INDEX_BITS-1:0] result_index,
  input  logic                  taken,
  input  logic                  result_predicted,
  output logic [31:0]           mispredict_count
);

  localparam int unsigned GhrW = (GHR_BITS > 0) ? GHR_BITS : 1;

  typedef logic [CTR_BITS-1:0] ctr_t;

  localparam ctr_t InitCtr = ctr_t'(INIT_CTR);

  logic [GhrW-1:0]       ghr_q, ghr_d;
  logic [INDEX_BITS-1:0] lookup_index;
  ctr_t                  lookup_ctr;
  idx_wide_t             pc_wide, ghr_wide, hash_wide;

  logic                  pred_q, pred_d;
  logic                  pvalid_q, pvalid_d;
  logic [INDEX_BITS-1:0] pidx_q, pidx_d;
  logic [31:0]           miss_q, miss_d;

  always_comb begin
    pc_wide  = idx_wide_t'(request_pc[INDEX_BITS+1:2]);
    ghr_wide = (GHR_BITS > 0) ? idx_wide_t'(ghr_q) : '0;
    hash_wide = bht_hash(pc_wide, ghr_wide);
    lookup_index = hash_wide[INDEX_BITS-1:0];
  end

  logic unused_hash;
  assign unused_hash = ^hash_wide[MaxIdxBits-1:INDEX_BITS];

  generate
    if (INDEX_BITS + 2 < PC_BITS) begin : g_unused_pc_hi
      logic unused_pc_hi;
      assign unused_pc_hi = ^request_pc[PC_BITS-1:INDEX_BITS+2];
    end
  endgenerate

  logic unused_pc_lo;
  assign unused_pc_lo = ^request_pc[1:0];

  predictor_table #(
    .INDEX_BITS (INDEX_BITS),
    .CTR_BITS   (CTR_BITS),
    .INIT_CTR   (INIT_CTR)
  ) u_table (
    .clk         (clk),
    .reset       (reset),
    .read_index  (lookup_index),
    .read_ctr    (lookup_ctr),
    .write_en    (result),
    .write_index (result_index),
    .write_taken (taken)
  );

  // Newest outcome enters at the LSB; bimodal keeps the register at zero.
  generate
    if (GHR_BITS == 0) begin : g_ghr_none
      assign ghr_d = '0;
    end else if (GHR_BITS == 1) begin : g_ghr_one
      assign ghr_d = taken;
    end else begin : g_ghr_shift
      assign ghr_d = {ghr_q[GhrW-2:0], taken};
    end
  endgenerate

  always_comb begin
    pred_d   = pred_q;
    pidx_d   = pidx_q;
    pvalid_d = 1'b0;
    miss_d   = miss_q;
    if (request) begin
      pred_d   = lookup_ctr[CTR_BITS-1];
      pidx_d   = lookup_index;
      pvalid_d = 1'b1;
    end
    if (result && (taken != result_predicted) && (miss_q != 32'hFFFF_FFFF)) begin
      miss_d = miss_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q    <= '0;
      pred_q   <= InitCtr[CTR_BITS-1];
      pidx_q   <= '0;
      pvalid_q <= 1'b0;
      miss_q   <= '0;
    end else begin
      if (result) begin
        ghr_q <= ghr_d;
      end
      pred_q   <= pred_d;
      pidx_q   <= pidx_d;
      pvalid_q <= pvalid_d;
      miss_q   <= miss_d;
    end
  end

  assign prediction       = pred_q;
  assign prediction_index = pidx_q;
  assign prediction_valid = pvalid_q;
  assign mispredict_count = miss_q;

endmodule

// File: tb/tb_bht_predictor.sv
// Self-checking bench for bht_predictor: directed vector table, randomized traffic
// against a reference model, counter saturation and mid-stream reset.
module tb_bht_predictor;

  localparam int unsigned CtrBits = 2;
  localparam int MaxCtr = (1 << CtrBits) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        request;
  logic [31:0] request_pc;
  logic        prediction;
  logic        prediction_valid;
  logic [5:0]  prediction_index;
  logic        result;
  logic [5:0]  result_index;
  logic        taken;
  logic        result_predicted;
  logic [31:0] mispredict_count;

  always #5 clk = ~clk;

  bht_predictor dut (
    .clk              (clk),
    .reset            (reset),
    .request          (request),
    .request_pc       (request_pc),
    .prediction       (prediction),
    .prediction_valid (prediction_valid),
    .prediction_index (prediction_index),
    .result           (result),
    .result_index     (result_index),
    .taken            (taken),
    .result_predicted (result_predicted),
    .mispredict_count (mispredict_count)
  );

  typedef struct {
    logic        req;
    logic [31:0] pc;
    logic        res;
    logic [5:0]  ridx;
    logic        tk;
    logic        rp;
    logic        exp_valid;
    logic        exp_pred;
    logic [5:0]  exp_idx;
    logic [31:0] exp_miss;
  } vec_t;

  typedef struct packed {
    logic       pred;
    logic [5:0] idx;
  } sb_t;

  vec_t   vecs[$];
  sb_t    sb_q[$];
  int     checks = 0;
  int     errors = 0;
  int     mdl_ctr[64];
  int     mdl_ghr;
  longint mdl_miss;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 64; i++) mdl_ctr[i] = MaxCtr;
    mdl_ghr  = 0;
    mdl_miss = 0;
  endtask

  task automatic add(input logic req, input logic [31:0] pc, input logic res,
                     input logic [5:0] ridx, input logic tk, input logic rp,
                     input logic ev, input logic ep, input logic [5:0] eidx,
                     input logic [31:0] emiss);
    vec_t v;
    v.req = req; v.pc = pc; v.res = res; v.ridx = ridx; v.tk = tk; v.rp = rp;
    v.exp_valid = ev; v.exp_pred = ep; v.exp_idx = eidx; v.exp_miss = emiss;
    vecs.push_back(v);
  endtask

  // Drive one cycle from a negedge, then check outputs at the following negedge.
  task automatic cycle(input logic rst, input logic req, input logic [31:0] pc,
                       input logic res, input logic [5:0] ridx, input logic tk,
                       input logic rp, input logic use_mdl);
    int   idx;
    logic exp_v;
    sb_t  e;
    reset = rst; request = req; request_pc = pc;
    result = res; result_index = ridx; taken = tk; result_predicted = rp;
    if (!rst && req && use_mdl) begin
      idx = (int'(pc[7:2]) ^ mdl_ghr) & 63;
      e.pred = ((mdl_ctr[idx] >> (CtrBits - 1)) & 1) != 0;
      e.idx  = 6'(idx);
      sb_q.push_back(e);
    end
    if (rst) begin
      mdl_reset();
    end else if (res) begin
      if (tk && mdl_ctr[ridx] < MaxCtr) mdl_ctr[ridx]++;
      if (!tk && mdl_ctr[ridx] > 0) mdl_ctr[ridx]--;
      mdl_ghr = ((mdl_ghr << 1) | int'(tk)) & 15;
      if (tk != rp && mdl_miss < 64'hFFFF_FFFF) mdl_miss++;
    end
    @(posedge clk);
    @(negedge clk);
    exp_v = (sb_q.size() != 0);
    chk("prediction_valid", 32'(prediction_valid), 32'(exp_v));
    if (exp_v) begin
      e = sb_q.pop_front();
      if (prediction_valid) begin
        chk("prediction", 32'(prediction), 32'(e.pred));
        chk("prediction_index", 32'(prediction_index), 32'(e.idx));
      end
    end
    chk("mispredict_count", mispredict_count, mdl_miss[31:0]);
  endtask

  initial begin
    sb_t e;
    reset = 1'b1; request = 1'b0; request_pc = '0;
    result = 1'b0; result_index = '0; taken = 1'b0; result_predicted = 1'b0;
    mdl_reset();

    // Directed vectors, defaults (INDEX_BITS=6, CTR_BITS=2, GHR_BITS=4).
    add(1, 32'h40, 0, 6'h00, 0, 0, 1, 1, 6'h10, 0);
    for (int i = 0; i < 4; i++) add(0, 32'h0, 1, 6'h10, 0, 0, 0, 0, 6'h00, 0);
    add(1, 32'h40, 0, 6'h00, 0, 0, 1, 0, 6'h10, 0);
    add(0, 32'h0,  1, 6'h10, 0, 0, 0, 0, 6'h00, 0);   // underflow attempt
    add(1, 32'h40, 0, 6'h00, 0, 0, 1, 0, 6'h10, 0);
    add(0, 32'h0,  1, 6'h20, 1, 1, 0, 0, 6'h00, 0);
    add(0, 32'h0,  1, 6'h20, 0, 0, 0, 0, 6'h00, 0);
    add(0, 32'h0,  1, 6'h20, 1, 1, 0, 0, 6'h00, 0);
    add(0, 32'h0,  1, 6'h20, 1, 1, 0, 0, 6'h00, 0);   // ghr = 4'b1011
    add(1, 32'h40, 0, 6'h00, 0, 0, 1, 1, 6'h1B, 0);
    add(0, 32'h0,  1, 6'h05, 0, 0, 0, 0, 6'h00, 0);   // ctr[5]=2, ghr=0110
    add(1, 32'h0C, 1, 6'h05, 0, 0, 1, 1, 6'h05, 0);   // read-before-write
    add(1, 32'h24, 0, 6'h00, 0, 0, 1, 0, 6'h05, 0);   // ghr=1100
    add(0, 32'h0,  1, 6'h30, 1, 0, 0, 0, 6'h00, 1);
    add(0, 32'h0,  1, 6'h30, 0, 1, 0, 0, 6'h00, 2);
    add(0, 32'h0,  1, 6'h30, 1, 1, 0, 0, 6'h00, 2);
    add(0, 32'h0,  1, 6'h30, 0, 0, 0, 0, 6'h00, 2);
    add(0, 32'h0,  1, 6'h30, 1, 0, 0, 0, 6'h00, 3);   // ghr=0101
    add(1, 32'h00, 0, 6'h00, 0, 0, 1, 0, 6'h05, 3);
    add(1, 32'hFC, 0, 6'h00, 0, 0, 1, 1, 6'h3A, 3);   // back-to-back

    @(negedge clk);
    // Reset with request/result asserted: both must be ignored.
    cycle(1, 1, 32'h40, 1, 6'h10, 0, 1, 1);
    chk("reset_prediction", 32'(prediction), 32'd1);
    chk("reset_index", 32'(prediction_index), 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].exp_valid) begin
        e.pred = vecs[i].exp_pred;
        e.idx  = vecs[i].exp_idx;
        sb_q.push_back(e);
      end
      cycle(0, vecs[i].req, vecs[i].pc, vecs[i].res, vecs[i].ridx, vecs[i].tk, vecs[i].rp, 0);
      chk($sformatf("vec%0d_miss", i), mispredict_count, vecs[i].exp_miss);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      cycle(0, ($urandom_range(0, 9) < 7), 32'($urandom), ($urandom_range(0, 1) == 1),
            6'($urandom), 1'($urandom), 1'($urandom), 1);
    end

    // Mispredict counter saturation from a preloaded value.
    dut.miss_q = 32'hFFFF_FFFD;
    mdl_miss   = 64'hFFFF_FFFD;
    for (int i = 0; i < 4; i++) cycle(0, 0, 32'h0, 1, 6'h01, 1, 0, 1);
    chk("miss_saturated", mispredict_count, 32'hFFFF_FFFF);

    // Train indices 0..3 to zero, then reset mid-stream with a pending request.
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 3; k++) cycle(0, 0, 32'h0, 1, 6'(j), 0, 0, 1);
    end
    cycle(0, 1, 32'h0, 0, 6'h00, 0, 0, 1);
    cycle(1, 1, 32'h8, 1, 6'h00, 0, 1, 1);
    chk("midreset_valid", 32'(prediction_valid), 32'd0);
    chk("midreset_miss", mispredict_count, 32'd0);
    chk("midreset_pred", 32'(prediction), 32'd1);
    for (int i = 0; i < 64; i++) begin
      cycle(0, 1, 32'(i) << 2, 0, 6'h00, 0, 0, 1);
      chk("post_reset_pred", 32'(prediction), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
